// File: rtl/wave_fm0_decode.sv
// FM0 bit decoder: calibrates the half-bit period from an 8-gap pilot, then
// classifies edge gaps as short/long half-bits and emits decoded bits.
module wave_fm0_decode #(
  parameter logic [15:0] MIN_HALF = 16'd4,
  parameter logic [15:0] MAX_BITS = 16'd512,
  parameter int unsigned CAL_GAPS = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        rise_edge_i,
  input  logic        fall_edge_i,
  input  logic [15:0] gap_i,
  output logic        bit_o,
  output logic        bit_valid_o,
  output logic        frame_end_o,
  output logic        err_o,
  output logic [15:0] half_period_o,
  output logic [15:0] bit_cnt_o,
  output logic        busy_o
);

  localparam int unsigned CAL_SHIFT = $clog2(CAL_GAPS);
  localparam int unsigned CAL_CNT_W = $clog2(CAL_GAPS + 1);
  localparam logic [CAL_CNT_W-1:0] CAL_LAST = CAL_CNT_W'(CAL_GAPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    DATA = 2'd2
  } state_e;

  // Threshold helpers, all in 18-bit unsigned so 16-bit H never overflows.
  function automatic logic [17:0] thr_short(input logic [15:0] h);
    return {2'b00, h} + {3'b000, h[15:1]};
  endfunction

  function automatic logic [17:0] thr_long(input logic [15:0] h);
    return {1'b0, h, 1'b0} + {3'b000, h[15:1]};
  endfunction

  function automatic logic [17:0] thr_timeout(input logic [15:0] h);
    return {h, 2'b00};
  endfunction

  state_e                 state_q, state_d;
  logic [18:0]            acc_q, acc_d;
  logic [15:0]            g0_q, g0_d;
  logic [CAL_CNT_W-1:0]   cal_cnt_q, cal_cnt_d;
  logic [17:0]            idle_q, idle_d;
  logic                   pend_q, pend_d;
  logic                   bit_q, bit_d;
  logic                   bit_vld_q, bit_vld_d;
  logic                   fend_q, fend_d;
  logic                   err_q, err_d;
  logic [15:0]            half_q, half_d;
  logic [15:0]            cnt_q, cnt_d;

  logic                   edge_w;
  logic [17:0]            gap18;
  logic [18:0]            cal_sum;
  logic [15:0]            h_new;
  logic                   cal_bad;
  logic [17:0]            ts, tl, to_lim;
  logic [17:0]            idle_inc;

  assign edge_w   = rise_edge_i | fall_edge_i;
  assign gap18    = {2'b00, gap_i};
  assign cal_sum  = acc_q + {3'b000, gap_i};
  assign h_new    = 16'(cal_sum >> CAL_SHIFT);
  assign cal_bad  = (gap18 > {1'b0, g0_q, 1'b0}) || (gap_i < {1'b0, g0_q[15:1]});
  assign ts       = thr_short(half_q);
  assign tl       = thr_long(half_q);
  assign to_lim   = thr_timeout(half_q);
  assign idle_inc = idle_q + 18'd1;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    g0_d      = g0_q;
    cal_cnt_d = cal_cnt_q;
    idle_d    = idle_q;
    pend_d    = pend_q;
    bit_d     = bit_q;
    bit_vld_d = 1'b0;
    fend_d    = 1'b0;
    err_d     = 1'b0;
    half_d    = half_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (edge_w) begin
          cnt_d     = '0;
          acc_d     = '0;
          g0_d      = '0;
          cal_cnt_d = '0;
          idle_d    = '0;
          pend_d    = 1'b0;
          state_d   = CAL;
        end
      end

      CAL: begin
        if (edge_w) begin
          // The very first pilot gap has no reference yet, so it is never rejected.
          if ((cal_cnt_q != '0) && cal_bad) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            if (cal_cnt_q == '0) g0_d = gap_i;
            acc_d     = cal_sum;
            cal_cnt_d = cal_cnt_q + 1'b1;
            if (cal_cnt_q == CAL_LAST) begin
              if (h_new < MIN_HALF) begin
                err_d   = 1'b1;
                state_d = IDLE;
              end else begin
                half_d  = h_new;
                pend_d  = 1'b0;
                idle_d  = '0;
                state_d = DATA;
              end
            end
          end
        end
      end

      DATA: begin
        if (cnt_q == MAX_BITS) begin
          fend_d  = 1'b1;
          pend_d  = 1'b0;
          state_d = IDLE;
        end else if (edge_w) begin
          idle_d = '0;
          if (gap18 >= tl) begin
            err_d   = 1'b1;
            pend_d  = 1'b0;
            state_d = IDLE;
          end else if (gap18 >= ts) begin
            if (pend_q) begin
              err_d   = 1'b1;
              pend_d  = 1'b0;
              state_d = IDLE;
            end else begin
              bit_d     = 1'b1;
              bit_vld_d = 1'b1;
              cnt_d     = cnt_q + 16'd1;
            end
          end else if (pend_q) begin
            bit_d     = 1'b0;
            bit_vld_d = 1'b1;
            cnt_d     = cnt_q + 16'd1;
            pend_d    = 1'b0;
          end else begin
            pend_d = 1'b1;
          end
        end else if (idle_inc >= to_lim) begin
          // Line went quiet: close the frame, dropping any half-bit in flight.
          fend_d  = 1'b1;
          pend_d  = 1'b0;
          state_d = IDLE;
        end else begin
          idle_d = idle_inc;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      g0_q      <= '0;
      cal_cnt_q <= '0;
      idle_q    <= '0;
      pend_q    <= 1'b0;
      bit_q     <= 1'b0;
      bit_vld_q <= 1'b0;
      fend_q    <= 1'b0;
      err_q     <= 1'b0;
      half_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      g0_q      <= g0_d;
      cal_cnt_q <= cal_cnt_d;
      idle_q    <= idle_d;
      pend_q    <= pend_d;
      bit_q     <= bit_d;
      bit_vld_q <= bit_vld_d;
      fend_q    <= fend_d;
      err_q     <= err_d;
      half_q    <= half_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bit_o         = bit_q;
  assign bit_valid_o   = bit_vld_q;
  assign frame_end_o   = fend_q;
  assign err_o         = err_q;
  assign half_period_o = half_q;
  assign bit_cnt_o     = cnt_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_wave_fm0_decode.sv
// Scoreboard bench for wave_fm0_decode: stimulus queues expected events,
// a forked monitor pops and compares whenever a DUT raises a strobe.
module tb_wave_fm0_decode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n_i;
  logic        rise1, fall1, rise2, fall2;
  logic [15:0] gap1, gap2;
  logic        bit1, bv1, fe1, er1, busy1;
  logic [15:0] half1, cnt1;
  logic        bit2, bv2, fe2, er2, busy2;
  logic [15:0] half2, cnt2;

  wave_fm0_decode dut1 (
    .clk_i(clk), .rst_n_i(rst_n_i), .rise_edge_i(rise1), .fall_edge_i(fall1),
    .gap_i(gap1), .bit_o(bit1), .bit_valid_o(bv1), .frame_end_o(fe1),
    .err_o(er1), .half_period_o(half1), .bit_cnt_o(cnt1), .busy_o(busy1)
  );

  wave_fm0_decode #(.MAX_BITS(16'd4)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n_i), .rise_edge_i(rise2), .fall_edge_i(fall2),
    .gap_i(gap2), .bit_o(bit2), .bit_valid_o(bv2), .frame_end_o(fe2),
    .err_o(er2), .half_period_o(half2), .bit_cnt_o(cnt2), .busy_o(busy2)
  );

  // kind: 0 = bit, 1 = err, 2 = frame_end; [lo,hi] = allowed monitor cycle
  typedef struct {
    int          inst;
    int          kind;
    logic        val;
    logic [15:0] cnt;
    int          lo;
    int          hi;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lc    = 0;
  logic tog   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic ev(input int inst, input int kind, input logic v, input logic [15:0] c);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: dut%0d kind %0d val %0d cnt %0d at cycle %0d, none expected",
               inst, kind, v, c, cyc);
    end else begin
      e = sb.pop_front();
      if (e.inst != inst || e.kind != kind || cyc < e.lo || cyc > e.hi ||
          (kind == 0 && (e.val !== v || e.cnt !== c))) begin
        n_bad++;
        $display("FAIL event: got dut%0d kind %0d val %0d cnt %0d cycle %0d; expected dut%0d kind %0d val %0d cnt %0d cycle %0d..%0d",
                 inst, kind, v, c, cyc, e.inst, e.kind, e.val, e.cnt, e.lo, e.hi);
      end
    end
  endtask

  task automatic send(input int inst, input logic [15:0] g, input bit both = 1'b0);
    @(posedge clk);
    #1;
    tog = ~tog;
    if (inst == 1) begin
      rise1 = tog | both; fall1 = ~tog | both; gap1 = g;
    end else begin
      rise2 = tog | both; fall2 = ~tog | both; gap2 = g;
    end
    @(posedge clk);
    #1;
    lc = cyc;
    rise1 = 1'b0; fall1 = 1'b0; rise2 = 1'b0; fall2 = 1'b0;
  endtask

  task automatic exp_bit(input int inst, input logic v, input logic [15:0] c);
    sb.push_back(exp_t'{inst, 0, v, c, lc, lc});
  endtask

  task automatic exp_err(input int inst);
    sb.push_back(exp_t'{inst, 1, 1'b0, 16'd0, lc, lc});
  endtask

  task automatic exp_fend(input int inst, input int lo, input int hi);
    sb.push_back(exp_t'{inst, 2, 1'b0, 16'd0, lo, hi});
  endtask

  task automatic cal(input int inst, input logic [15:0] start, input logic [15:0] g);
    send(inst, start);
    repeat (8) send(inst, g);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0;
    rst_n_i = 1'b0;
    rise1 = 1'b0; fall1 = 1'b0; gap1 = '0;
    rise2 = 1'b0; fall2 = 1'b0; gap2 = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n_i) begin
          if ((er1 || fe1)) chk("err_fend_excl1", {31'd0, er1 & fe1}, 32'd0);
          if ((er2 || fe2)) chk("err_fend_excl2", {31'd0, er2 & fe2}, 32'd0);
          if (bv1) ev(1, 0, bit1, cnt1);
          if (er1) ev(1, 1, 1'b0, 16'd0);
          if (fe1) ev(1, 2, 1'b0, 16'd0);
          if (bv2) ev(2, 0, bit2, cnt2);
          if (er2) ev(2, 1, 1'b0, 16'd0);
          if (fe2) ev(2, 2, 1'b0, 16'd0);
        end
      end
    join_none

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bit", bit1, 0);
    chk("rst_bv", bv1, 0);
    chk("rst_fe", fe1, 0);
    chk("rst_err", er1, 0);
    chk("rst_half", half1, 0);
    chk("rst_cnt", cnt1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_busy2", busy2, 0);
    rst_n_i = 1'b1;

    // calibration with 8 gaps of 10
    cal(1, 16'd123, 16'd10);
    chk("cal_half", half1, 10);
    chk("cal_busy", busy1, 1);
    chk("cal_cnt", cnt1, 0);

    // 20,10,10,20 -> 1,0,1 (one edge has rise and fall together)
    send(1, 16'd20);         exp_bit(1, 1'b1, 16'd1);
    send(1, 16'd10, 1'b1);
    send(1, 16'd10);         exp_bit(1, 1'b0, 16'd2);
    send(1, 16'd20);         exp_bit(1, 1'b1, 16'd3);
    chk("data_cnt", cnt1, 3);

    // short then long -> error
    send(1, 16'd10);
    send(1, 16'd20);         exp_err(1);
    chk("sl_busy", busy1, 0);
    chk("sl_cnt", cnt1, 3);
    chk("sl_bit_hold", bit1, 1);

    // new frame; edge lands exactly when idle counter would reach TO=40
    cal(1, 16'd7, 16'd10);
    chk("frame2_cnt", cnt1, 0);
    c0 = lc;
    while (cyc < c0 + 38) begin
      @(posedge clk);
      #1;
    end
    send(1, 16'd20);
    chk("to_edge_cycle", lc, c0 + 40);
    exp_bit(1, 1'b1, 16'd1);
    exp_fend(1, lc + 39, lc + 41);
    repeat (45) @(posedge clk);
    #1;
    chk("to_busy", busy1, 0);
    chk("to_half_hold", half1, 10);
    chk("to_cnt_hold", cnt1, 1);

    // calibration errors: too long, too short, H below MIN_HALF
    send(1, 16'd5); send(1, 16'd10); send(1, 16'd25); exp_err(1);
    chk("cal_long_busy", busy1, 0);
    send(1, 16'd5); send(1, 16'd10); send(1, 16'd4);  exp_err(1);
    send(1, 16'd5);
    repeat (8) send(1, 16'd2);
    exp_err(1);
    chk("minhalf_busy", busy1, 0);
    chk("minhalf_half_hold", half1, 10);

    // asynchronous reset mid-frame
    cal(1, 16'd9, 16'd10);
    send(1, 16'd20);         exp_bit(1, 1'b1, 16'd1);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #3;
    rst_n_i = 1'b0;
    #1;
    chk("arst_half", half1, 0);
    chk("arst_busy", busy1, 0);
    chk("arst_cnt", cnt1, 0);
    chk("arst_bit", bit1, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    cal(1, 16'd3, 16'd12);
    chk("rerun_half", half1, 12);
    chk("rerun_busy", busy1, 1);
    exp_fend(1, lc + 47, lc + 49);
    repeat (55) @(posedge clk);
    #1;

    // MAX_BITS = 4 instance
    cal(2, 16'd1, 16'd10);
    for (int k = 1; k <= 4; k++) begin
      send(2, 16'd20);
      exp_bit(2, 1'b1, 16'(k));
    end
    exp_fend(2, lc + 1, lc + 1);
    repeat (4) @(posedge clk);
    #1;
    chk("max_busy", busy2, 0);
    chk("max_cnt", cnt2, 4);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
